clk_phase_gen: RTL and testbench
================================

CLK_PHASE_GEN -- requirements
Module: clk_phase_gen

Interface
REQ-001 Parameter DIV_W, 8, width of divisor and phase counter.
REQ-002 Parameter PHASES, 4, number of evenly spaced phase strobes (2..8).
REQ-003 Parameter DIV_INIT, 4, divisor loaded at reset (>= max(2,PHASES)).
REQ-004 Parameter LOCK_PERIODS, 8, full output periods counted before lock asserts.
REQ-005 clock_i  in  1  single clock; all logic on rising edge.
REQ-006 reset_ni  in  1  asynchronous, active-low reset.
REQ-007 div_req_i  in  1  divisor-change request; held high until div_ack_o.
REQ-008 div_val_i  in  DIV_W  requested divisor; stable while div_req_i high.
REQ-009 div_ack_o  out  1  one-cycle acknowledge of a request.
REQ-010 div_err_o  out  1  valid with div_ack_o; high = request rejected.
REQ-011 phase_en_o  out  PHASES  per-phase one-cycle clock-enable strobes.
REQ-012 div_en_o  out  1  one-cycle strobe at end of each divided period.
REQ-013 clk_div_o  out  1  registered divided square wave.
REQ-014 locked_o  out  1  high when outputs are stable at the current divisor.

Function
REQ-015 Phase counter cnt SHALL count 0..div-1, wrapping to 0 after div-1, every cycle.
REQ-016 div_en_o SHALL be high in exactly the cycle cnt == div-1, gated by locked_o.
REQ-017 phase_en_o[k] SHALL be high in exactly the cycle cnt == floor(k*div/PHASES), gated by locked_o.
REQ-018 clk_div_o SHALL be high while cnt < ceil(div/2), else low; driven regardless of lock.
REQ-019 FSM states SHALL be IDLE (reset only), LOCKING, LOCKED.
REQ-020 IDLE -> LOCKING on the first clock after reset release.
REQ-021 LOCKING SHALL count div_en events (ungated); after LOCK_PERIODS events -> LOCKED; locked_o high from the following cycle.
REQ-022 LOCKED -> LOCKING on any accepted divisor change; locked_o low from the ack cycle.
REQ-023 A request is seen when div_req_i is high and div_ack_o is low; div_ack_o SHALL go high the next cycle for one cycle only.
REQ-024 Request with div_val_i < max(2,PHASES) SHALL be rejected: div_err_o high, divisor, counter and lock unaffected.
REQ-025 Accepted request: in the ack cycle div holds the new value, cnt == 0, div_err_o low, lock counter cleared.
REQ-026 Request equal to current divisor SHALL still be accepted and force relock.
REQ-027 Request arriving in LOCKING SHALL be accepted and restart the lock count.
REQ-028 div_req_i remaining high in the ack cycle SHALL NOT generate a second ack; a new request needs div_req_i low for at least one cycle.
REQ-029 Arithmetic: floor(k*div/PHASES) computed at DIV_W+3 bits, truncated to DIV_W; no overflow for div <= 2^DIV_W-1.

Reset
REQ-030 While reset_ni low: cnt=0, div=DIV_INIT, state IDLE, lock count 0; all outputs 0.
REQ-031 Reset asserted mid-operation SHALL abort any pending request without acknowledge.

Structure
REQ-032 FSM state encoding and the minimum-divisor function belong in shared package clk_gen_pkg.
REQ-033 The lock-period counter SHALL be a sub-module clk_lock_ctr (start, event, done).

Verification
REQ-034 Reset release, DIV_INIT=4, PHASES=4 -> locked_o high after 8 periods (~33 cycles); then phase_en_o = 0001,0010,0100,1000 cyclically, div_en_o with bit 3.
REQ-035 Request div_val=10 while locked -> ack next cycle, err=0, locked_o low; phase strobes at cnt 0,2,5,7; relock after 80 cycles.
REQ-036 Request div_val=3 (PHASES=4) -> ack with err=1; strobe sequence and locked_o unchanged.
REQ-037 div_req_i held high 5 cycles -> exactly one ack pulse.
REQ-038 Request div_val=5 in LOCKING period 6 -> lock count restarts; clk_div_o high 3 cycles, low 2.
REQ-039 reset_ni low mid-request -> all outputs 0 immediately; no ack after release; divisor back to DIV_INIT.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: FSM state encoding and minimum legal divisor shared by the clk_phase_gen slice
package clk_gen_pkg;
    typedef enum logic [1:0] {IDLE, LOCKING, LOCKED} state_t;
    function automatic int min_div(input int phases);
        return (phases > 2) ? phases : 2;
    endfunction
endpackage

// File: rtl/clk_lock_ctr.sv
// clk_lock_ctr: counts event pulses and flags the LOCK_PERIODS-th one since the last start
module clk_lock_ctr #(
    parameter int LOCK_PERIODS = 8
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic i_start,
    input  logic i_event,
    output logic o_done
);
    localparam int CW = $clog2(LOCK_PERIODS + 1);
    logic [CW-1:0] r_cnt;
    assign o_done = i_event && (r_cnt == CW'(LOCK_PERIODS - 1));
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) r_cnt <= '0;
        else if (i_start || o_done) r_cnt <= '0;
        else if (i_event) r_cnt <= r_cnt + CW'(1);
    end
endmodule

// File: rtl/clk_phase_gen.sv
// clk_phase_gen: programmable divider producing phase strobes, period strobe, square wave and lock
module clk_phase_gen
    import clk_gen_pkg::*;
#(
    parameter int DIV_W        = 8,
    parameter int PHASES       = 4,
    parameter int DIV_INIT     = 4,
    parameter int LOCK_PERIODS = 8
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              div_req_i,
    input  logic [DIV_W-1:0]  div_val_i,
    output logic              div_ack_o,
    output logic              div_err_o,
    output logic [PHASES-1:0] phase_en_o,
    output logic              div_en_o,
    output logic              clk_div_o,
    output logic              locked_o
);
    localparam int PW = DIV_W + 3;
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(min_div(PHASES));
    state_t r_state, w_state_nxt;
    logic [DIV_W-1:0] r_cnt, r_div, w_cnt_nxt, w_div_nxt;
    logic [DIV_W:0] w_half;
    logic r_ack, r_err, r_busy, r_clk_div;
    logic w_seen, w_accept, w_wrap, w_done;
    // r_busy stays set until the requester drops div_req_i, so a held request acks once
    assign w_seen    = div_req_i && !r_ack && !r_busy;
    assign w_accept  = w_seen && (div_val_i >= MIN_DIV);
    assign w_wrap    = r_cnt == r_div - DIV_W'(1);
    assign w_cnt_nxt = (w_accept || w_wrap) ? '0 : r_cnt + DIV_W'(1);
    assign w_div_nxt = w_accept ? div_val_i : r_div;
    assign w_half    = ({1'b0, w_div_nxt} + (DIV_W+1)'(1)) >> 1;
    clk_lock_ctr #(.LOCK_PERIODS(LOCK_PERIODS)) u_lock (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .i_start  (w_accept),
        .i_event  (w_wrap && r_state == LOCKING),
        .o_done   (w_done)
    );
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE || w_accept) w_state_nxt = LOCKING;
        else if (r_state == LOCKING && w_done) w_state_nxt = LOCKED;
    end
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_cnt     <= '0;
            r_div     <= DIV_W'(DIV_INIT);
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_clk_div <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_div     <= w_div_nxt;
            r_ack     <= w_seen;
            r_err     <= w_seen && !w_accept;
            r_busy    <= div_req_i && (r_busy || w_seen);
            r_clk_div <= {1'b0, w_cnt_nxt} < w_half;
        end
    end
    assign div_ack_o = r_ack;
    assign div_err_o = r_err;
    assign clk_div_o = r_clk_div;
    assign locked_o  = r_state == LOCKED;
    assign div_en_o  = locked_o && w_wrap;
    for (genvar k = 0; k < PHASES; k++) begin : g_ph
        logic [PW-1:0] w_pos;
        assign w_pos = (PW'(k) * {3'b000, r_div}) / PW'(PHASES);
        assign phase_en_o[k] = locked_o && ({3'b000, r_cnt} == w_pos);
    end
endmodule

// File: tb/tb_clk_phase_gen.sv
// tb_clk_phase_gen: randomized requests checked by a scoreboard against a time-since-origin model
module tb_clk_phase_gen;
    localparam int PHASES = 4;
    localparam int DIV_INIT = 4;
    localparam int LP = 8;
    localparam int MIN_DIV = 4;
    typedef struct {
        int t;
        bit err;
        int div;
    } exp_t;
    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    logic req = 1'b0;
    logic [7:0] val_i = 8'd0;
    logic div_ack_o, div_err_o, div_en_o, clk_div_o, locked_o;
    logic [PHASES-1:0] phase_en_o;
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int m_div = DIV_INIT;
    int m_t0 = 0;
    int m_rst_t = 0;
    exp_t q[$];
    exp_t e;
    int d, cnt;
    bit lk, eack, eerr;
    logic [PHASES-1:0] eph;
    clk_phase_gen #(.DIV_W(8), .PHASES(PHASES), .DIV_INIT(DIV_INIT), .LOCK_PERIODS(LP)) dut (
        .clock_i    (clk),
        .reset_ni   (reset_ni),
        .div_req_i  (req),
        .div_val_i  (val_i),
        .div_ack_o  (div_ack_o),
        .div_err_o  (div_err_o),
        .phase_en_o (phase_en_o),
        .div_en_o   (div_en_o),
        .clk_div_o  (clk_div_o),
        .locked_o   (locked_o)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h div=%0d", name, cyc, act, exp, m_div);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic request(input int v, input int hold);
        exp_t x;
        req = 1'b1;
        val_i = 8'(v);
        x.t = cyc + 1;
        x.err = v < MIN_DIV;
        x.div = v;
        q.push_back(x);
        tick(hold);
        req = 1'b0;
        tick(1);
    endtask
    task automatic do_reset(input int n);
        reset_ni = 1'b0;
        q.delete();
        tick(n);
        reset_ni = 1'b1;
        m_div = DIV_INIT;
        m_t0 = cyc;
        m_rst_t = cyc;
    endtask
    // monitor: expected outputs follow from cycles elapsed since the last divisor origin
    always @(negedge clk) begin
        if (!reset_ni) begin
            chk("rst_ack", div_ack_o, 0);
            chk("rst_err", div_err_o, 0);
            chk("rst_phase", phase_en_o, 0);
            chk("rst_div_en", div_en_o, 0);
            chk("rst_clk_div", clk_div_o, 0);
            chk("rst_locked", locked_o, 0);
        end else begin
            eack = 0;
            eerr = 0;
            if (q.size() > 0 && q[0].t == cyc) begin
                e = q.pop_front();
                eack = 1;
                eerr = e.err;
                if (!e.err) begin
                    m_div = e.div;
                    m_t0 = cyc;
                end
            end
            d = cyc - m_t0;
            cnt = d % m_div;
            lk = d >= LP * m_div;
            eph = '0;
            for (int k = 0; k < PHASES; k++) eph[k] = lk && (cnt == k * m_div / PHASES);
            chk("ack", div_ack_o, eack);
            if (eack) chk("err", div_err_o, eerr);
            chk("locked", locked_o, lk);
            chk("div_en", div_en_o, lk && (cnt == m_div - 1));
            chk("phase", phase_en_o, eph);
            chk("clk_div", clk_div_o, (cyc == m_rst_t) ? 0 : (cnt < (m_div + 1) / 2));
        end
    end
    initial begin
        int v, h;
        do_reset(4);
        tick(45);
        request(10, 1);
        tick(90);
        request(3, 1);
        tick(10);
        request(6, 5);
        tick(20);
        request(5, 1);
        tick(50);
        request(5, 1);
        tick(45);
        request(255, 2);
        tick(2100);
        request(0, 1);
        request(1, 1);
        request(2, 1);
        request(4, 3);
        tick(40);
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(0, 24);
            h = $urandom_range(1, 5);
            request(v, h);
            tick($urandom_range(0, 60));
        end
        tick(50);
        req = 1'b1;
        val_i = 8'd9;
        #2;
        do_reset(3);
        tick(3);
        req = 1'b0;
        tick(45);
        request(7, 1);
        tick(60);
        chk("pending_acks", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
